// File: rtl/burst_ram_arbiter.sv
// burst_ram_arbiter: round-robin sharing of one PSRAM burst port between two cache clients
module burst_ram_arbiter #(
  parameter int RAM_DEPTH_BITWIDTH = 21,
  parameter int COMMAND_DELAY_INTERVAL = 13,
  parameter int BURST_BEATS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          m0_cmd,
  input  logic                          m0_cmd_en,
  input  logic [RAM_DEPTH_BITWIDTH-1:0] m0_addr,
  input  logic [63:0]                   m0_wr_data,
  output logic [63:0]                   m0_rd_data,
  output logic                          m0_rd_data_valid,
  input  logic                          m1_cmd,
  input  logic                          m1_cmd_en,
  input  logic [RAM_DEPTH_BITWIDTH-1:0] m1_addr,
  input  logic [63:0]                   m1_wr_data,
  output logic [63:0]                   m1_rd_data,
  output logic                          m1_rd_data_valid,
  output logic                          br_cmd,
  output logic                          br_cmd_en,
  output logic [RAM_DEPTH_BITWIDTH-1:0] br_addr,
  output logic [63:0]                   br_wr_data,
  output logic [7:0]                    br_data_mask,
  input  logic [63:0]                   br_rd_data,
  input  logic                          br_rd_data_valid,
  output logic                          overflow
);
  localparam int AW = RAM_DEPTH_BITWIDTH;
  localparam int BW = $clog2(BURST_BEATS);
  localparam logic [BW:0] FULL = (BW+1)'(BURST_BEATS);
  localparam logic [BW-1:0] LAST = BW'(BURST_BEATS - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WR_BEATS, RD_WAIT} state_t;
  state_t state, state_nx;
  logic cmd_en [2];
  logic cmd [2];
  logic [AW-1:0] addr [2];
  logic [63:0] wr_data [2];
  logic [AW:0] q [2][2];
  logic [1:0] q_cnt [2];
  logic [63:0] wbuf [2][BURST_BEATS];
  logic [BW:0] wb_cnt [2];
  logic wb_busy [2];
  logic elig [2];
  logic pop [2];
  logic push [2];
  logic drop [2];
  logic wfree [2];
  logic [5:0] dly;
  logic owner, last_grant, grant, last_beat;
  logic [BW-1:0] beat;
  logic [AW:0] head;
  assign cmd_en[0] = m0_cmd_en;
  assign cmd_en[1] = m1_cmd_en;
  assign cmd[0] = m0_cmd;
  assign cmd[1] = m1_cmd;
  assign addr[0] = m0_addr;
  assign addr[1] = m1_addr;
  assign wr_data[0] = m0_wr_data;
  assign wr_data[1] = m1_wr_data;
  assign head = q[owner][0];
  assign last_beat = beat == LAST;
  assign grant = elig[0] && elig[1] ? !last_grant : elig[1];
  assign m0_rd_data = br_rd_data;
  assign m1_rd_data = br_rd_data;
  assign m0_rd_data_valid = state == RD_WAIT && !owner && br_rd_data_valid;
  assign m1_rd_data_valid = state == RD_WAIT && owner && br_rd_data_valid;
  assign br_cmd_en = state == ISSUE;
  assign br_cmd = state == ISSUE && head[AW];
  assign br_addr = state == ISSUE ? head[AW-1:0] : '0;
  assign br_wr_data = state == ISSUE && head[AW] ? wbuf[owner][0] : state == WR_BEATS ? wbuf[owner][beat] : '0;
  assign br_data_mask = '0;
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      elig[i] = q_cnt[i] != 2'd0 && (!q[i][0][AW] || wb_cnt[i] == FULL);
      pop[i] = state == ISSUE && owner == 1'(i);
      wfree[i] = state == WR_BEATS && owner == 1'(i) && last_beat;
      push[i] = cmd_en[i] && !((q_cnt[i] == 2'd2 && !pop[i]) || (cmd[i] && wb_busy[i]));
      drop[i] = cmd_en[i] && !push[i];
    end
    state_nx = state == IDLE ? ((dly == 6'd0 && (elig[0] || elig[1])) ? ISSUE : IDLE)
             : state == ISSUE ? (head[AW] ? WR_BEATS : RD_WAIT)
             : state == WR_BEATS ? (last_beat ? IDLE : WR_BEATS)
             : (br_rd_data_valid && last_beat) ? IDLE : RD_WAIT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dly <= '0;
      owner <= 1'b0;
      last_grant <= 1'b1;
      beat <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        q_cnt[i] <= '0;
        wb_cnt[i] <= '0;
        wb_busy[i] <= 1'b0;
      end
    end else begin
      state <= state_nx;
      // loaded two short so the following IDLE->ISSUE lands exactly the interval after this issue
      dly <= state == ISSUE ? 6'(COMMAND_DELAY_INTERVAL - 2) : dly - 6'(dly != 6'd0);
      overflow <= overflow | drop[0] | drop[1];
      if (state == IDLE && state_nx == ISSUE) begin
        owner <= grant;
        last_grant <= grant;
      end
      beat <= state == ISSUE ? BW'(head[AW])
            : (state == WR_BEATS || (state == RD_WAIT && br_rd_data_valid)) ? beat + BW'(1) : beat;
      for (int i = 0; i < 2; i++) begin
        if (pop[i]) q[i][0] <= q[i][1];
        if (push[i]) q[i][q_cnt[i][1] | (q_cnt[i][0] & !pop[i])] <= {cmd[i], addr[i]};
        q_cnt[i] <= q_cnt[i] + 2'(push[i]) - 2'(pop[i]);
        if (push[i] && cmd[i]) begin
          wbuf[i][0] <= wr_data[i];
          wb_cnt[i] <= (BW+1)'(1);
          wb_busy[i] <= 1'b1;
        end else if (wb_busy[i] && wb_cnt[i] != FULL) begin
          wbuf[i][wb_cnt[i][BW-1:0]] <= wr_data[i];
          wb_cnt[i] <= wb_cnt[i] + (BW+1)'(1);
        end
        if (wfree[i]) begin
          wb_busy[i] <= 1'b0;
          wb_cnt[i] <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_burst_ram_arbiter.sv
// tb_burst_ram_arbiter: table vectors, directed corner sequences and randomized traffic for burst_ram_arbiter
module tb_burst_ram_arbiter;
  localparam int AW = 21;
  logic clk = 0, rst = 1;
  logic m0_cmd, m0_cmd_en, m1_cmd, m1_cmd_en;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [63:0] m0_wr_data, m1_wr_data, m0_rd_data, m1_rd_data;
  logic m0_rd_data_valid, m1_rd_data_valid;
  logic br_cmd, br_cmd_en, br_rd_data_valid, overflow;
  logic [AW-1:0] br_addr;
  logic [63:0] br_wr_data, br_rd_data;
  logic [7:0] br_data_mask;

  burst_ram_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_cmd(m0_cmd), .m0_cmd_en(m0_cmd_en), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
    .m0_rd_data(m0_rd_data), .m0_rd_data_valid(m0_rd_data_valid),
    .m1_cmd(m1_cmd), .m1_cmd_en(m1_cmd_en), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
    .m1_rd_data(m1_rd_data), .m1_rd_data_valid(m1_rd_data_valid),
    .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr), .br_wr_data(br_wr_data),
    .br_data_mask(br_data_mask), .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid),
    .overflow(overflow)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: logs every downstream command and audits read-beat routing and command spacing.
  logic [AW-1:0] iss_addr [512];
  logic iss_cmd [512];
  int iss_cyc [512];
  logic [63:0] iss_d [512][4];
  int n_iss = 0, last_iss = -100, bad_route = 0, bad_gap = 0;
  int vcnt [2] = '{0, 0};
  int seen [2] = '{0, 0};
  initial begin
    int wcap;
    wcap = 0;
    forever begin
      @(negedge clk);
      if (wcap > 0) begin
        iss_d[n_iss-1][4-wcap] = br_wr_data;
        wcap--;
      end
      if (br_cmd_en) begin
        if (cyc - last_iss < 13) bad_gap++;
        last_iss = cyc;
        iss_addr[n_iss] = br_addr;
        iss_cmd[n_iss] = br_cmd;
        iss_cyc[n_iss] = cyc;
        iss_d[n_iss][0] = br_wr_data;
        seen[br_addr[20]]++;
        n_iss++;
        wcap = br_cmd ? 3 : 0;
      end
      if (m0_rd_data_valid) begin
        vcnt[0]++;
        if (m1_rd_data_valid || !br_rd_data_valid || m0_rd_data !== br_rd_data || br_rd_data[20]) bad_route++;
      end
      if (m1_rd_data_valid) begin
        vcnt[1]++;
        if (!br_rd_data_valid || m1_rd_data !== br_rd_data || !br_rd_data[20]) bad_route++;
      end
    end
  end

  // Memory controller model: four read beats tagged with the burst address and beat number.
  bit rand_lat = 0;
  initial begin
    logic [AW-1:0] a;
    int lat;
    br_rd_data_valid = 0;
    br_rd_data = '0;
    forever begin
      @(negedge clk);
      if (br_cmd_en && !br_cmd) begin
        a = br_addr;
        lat = rand_lat ? int'($urandom_range(1, 3)) : 2;
        repeat (lat) @(posedge clk);
        for (int b = 0; b < 4; b++) begin
          #1;
          br_rd_data_valid = 1;
          br_rd_data = {32'hD00D_0000 | 32'(b), 11'h0, a};
          @(posedge clk);
        end
        #1;
        br_rd_data_valid = 0;
        br_rd_data = '0;
      end
    end
  end

  logic [63:0] pb [2][3];
  int pn [2] = '{0, 0};
  task automatic set_port(input int p, input logic en, input logic c, input logic [AW-1:0] a, input logic [63:0] d);
    if (p == 0) begin
      m0_cmd_en = en; m0_cmd = c; m0_addr = a; m0_wr_data = d;
    end else begin
      m1_cmd_en = en; m1_cmd = c; m1_addr = a; m1_wr_data = d;
    end
  endtask
  task automatic send(input int p, input logic c, input logic [AW-1:0] a, input logic [63:0] base);
    set_port(p, 1'b1, c, a, base);
    if (c) begin
      for (int k = 0; k < 3; k++) pb[p][k] = base + 64'(k + 1);
      pn[p] = 3;
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      if (pn[p] > 0) begin
        set_port(p, 1'b0, 1'b0, '0, pb[p][3-pn[p]]);
        pn[p]--;
      end else set_port(p, 1'b0, 1'b0, '0, '0);
    end
  endtask
  task automatic wait_to(input int t);
    while (cyc < t) tick;
  endtask
  task automatic wait_iss(input int n, input int budget);
    int t0;
    t0 = cyc;
    while (n_iss < n && cyc - t0 < budget) tick;
  endtask
  task automatic do_reset;
    rst = 1;
    tick;
    rst = 0;
    repeat (16) tick;
  endtask

  typedef struct {
    int p;
    logic c;
    logic [AW-1:0] a;
    logic [63:0] base;
    int lat;
    int nv;
  } vec_t;
  vec_t tbl [4];

  logic [AW-1:0] e_a [2][256];
  logic e_c [2][256];
  logic [63:0] e_b [2][256];
  int ne [2], nrd [2], idx [2], s0 [2], vs [2];

  initial begin
    int b0, c0, v0, v1, p, j;
    logic c;
    logic [AW-1:0] a;
    logic [63:0] base;
    tbl[0] = '{p: 0, c: 1'b0, a: 21'h000100, base: 64'h0, lat: 2, nv: 4};
    tbl[1] = '{p: 1, c: 1'b0, a: 21'h100200, base: 64'h0, lat: 2, nv: 4};
    tbl[2] = '{p: 1, c: 1'b1, a: 21'h000040, base: 64'hA0A0_0000_0000_0000, lat: 5, nv: 0};
    tbl[3] = '{p: 0, c: 1'b1, a: 21'h1FFFFF, base: 64'hFFFF_FFFF_FFFF_FFFE, lat: 5, nv: 0};
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst br_cmd_en", 64'(br_cmd_en), 0);
    chk("rst br_cmd", 64'(br_cmd), 0);
    chk("rst br_addr", 64'(br_addr), 0);
    chk("rst br_wr_data", br_wr_data, 0);
    chk("rst mask", 64'(br_data_mask), 0);
    chk("rst rd_valid", 64'({m0_rd_data_valid, m1_rd_data_valid}), 0);
    chk("rst overflow", 64'(overflow), 0);
    @(posedge clk);
    #1;
    rst = 0;
    repeat (16) tick;

    for (int i = 0; i < 4; i++) begin
      b0 = n_iss; v0 = vcnt[0]; v1 = vcnt[1]; c0 = cyc;
      send(tbl[i].p, tbl[i].c, tbl[i].a, tbl[i].base);
      wait_iss(b0 + 1, 30);
      repeat (12) tick;
      chk($sformatf("row%0d issued", i), 64'(n_iss - b0), 1);
      chk($sformatf("row%0d latency", i), 64'(iss_cyc[b0] - c0), 64'(tbl[i].lat));
      chk($sformatf("row%0d br_cmd", i), 64'(iss_cmd[b0]), 64'(tbl[i].c));
      chk($sformatf("row%0d br_addr", i), 64'(iss_addr[b0]), 64'(tbl[i].a));
      if (tbl[i].c)
        for (int k = 0; k < 4; k++) chk($sformatf("row%0d beat%0d", i, k), iss_d[b0][k], tbl[i].base + 64'(k));
      chk($sformatf("row%0d own beats", i), 64'(tbl[i].p == 0 ? vcnt[0] - v0 : vcnt[1] - v1), 64'(tbl[i].nv));
      chk($sformatf("row%0d other beats", i), 64'(tbl[i].p == 0 ? vcnt[1] - v1 : vcnt[0] - v0), 0);
      chk($sformatf("row%0d mask", i), 64'(br_data_mask), 0);
      do_reset;
    end

    b0 = n_iss; c0 = cyc;
    send(0, 1'b0, 21'h000100, '0);
    send(1, 1'b0, 21'h100200, '0);
    wait_iss(b0 + 2, 40);
    chk("tie first addr", 64'(iss_addr[b0]), 64'h100);
    chk("tie first latency", 64'(iss_cyc[b0] - c0), 2);
    chk("tie second addr", 64'(iss_addr[b0+1]), 64'h100200);
    chk("tie spacing", 64'(iss_cyc[b0+1] - iss_cyc[b0]), 13);
    repeat (20) tick;
    b0 = n_iss;
    send(0, 1'b0, 21'h000104, '0);
    send(1, 1'b0, 21'h100204, '0);
    wait_iss(b0 + 2, 40);
    chk("tie after m1 grant", 64'(iss_addr[b0]), 64'h104);
    repeat (20) tick;
    b0 = n_iss;
    send(0, 1'b0, 21'h000108, '0);
    wait_iss(b0 + 1, 20);
    repeat (20) tick;
    b0 = n_iss;
    send(0, 1'b0, 21'h00010C, '0);
    send(1, 1'b0, 21'h10020C, '0);
    wait_iss(b0 + 2, 40);
    chk("tie after m0 grant first", 64'(iss_addr[b0]), 64'h10020C);
    chk("tie after m0 grant second", 64'(iss_addr[b0+1]), 64'h10C);
    do_reset;

    b0 = n_iss; c0 = cyc;
    send(0, 1'b0, 21'h000100, '0);
    send(1, 1'b1, 21'h000040, 64'h5555_0000_0000_0010);
    tick;
    send(0, 1'b0, 21'h000180, '0);
    wait_to(c0 + 13);
    send(1, 1'b0, 21'h100300, '0);
    wait_iss(b0 + 4, 80);
    chk("mix order0", 64'(iss_addr[b0]), 64'h100);
    chk("mix order1", 64'(iss_addr[b0+1]), 64'h40);
    chk("mix order2", 64'(iss_addr[b0+2]), 64'h180);
    chk("mix order3", 64'(iss_addr[b0+3]), 64'h100300);
    chk("mix write cmd", 64'(iss_cmd[b0+1]), 1);
    for (int k = 0; k < 4; k++) chk($sformatf("mix beat%0d", k), iss_d[b0+1][k], 64'h5555_0000_0000_0010 + 64'(k));
    for (int k = 0; k < 4; k++) chk($sformatf("mix cycle%0d", k), 64'(iss_cyc[b0+k] - c0), 64'(2 + 13 * k));
    chk("mix overflow", 64'(overflow), 0);
    do_reset;

    b0 = n_iss; c0 = cyc;
    send(1, 1'b0, 21'h100010, '0);
    wait_to(c0 + 3);
    send(0, 1'b0, 21'h000010, '0);
    tick;
    send(0, 1'b0, 21'h000020, '0);
    tick;
    send(0, 1'b0, 21'h000030, '0);
    chk("ovf before drop", 64'(overflow), 0);
    tick;
    chk("ovf after drop", 64'(overflow), 1);
    wait_to(c0 + 15);
    send(0, 1'b0, 21'h000040, '0);
    wait_to(c0 + 70);
    chk("drop issue count", 64'(n_iss - b0), 4);
    chk("drop order0", 64'(iss_addr[b0]), 64'h100010);
    chk("drop order1", 64'(iss_addr[b0+1]), 64'h10);
    chk("drop order2", 64'(iss_addr[b0+2]), 64'h20);
    chk("pop+push accepted", 64'(iss_addr[b0+3]), 64'h40);
    chk("pop+push cycle", 64'(iss_cyc[b0+3] - c0), 41);
    chk("ovf sticky", 64'(overflow), 1);
    do_reset;
    chk("ovf cleared", 64'(overflow), 0);

    v0 = vcnt[0]; c0 = cyc;
    send(0, 1'b0, 21'h000100, '0);
    wait_to(c0 + 3);
    rst = 1;
    tick;
    rst = 0;
    @(negedge clk);
    chk("midrst br_cmd_en", 64'(br_cmd_en), 0);
    chk("midrst br_addr", 64'(br_addr), 0);
    chk("midrst br_wr_data", br_wr_data, 0);
    chk("midrst beat present", 64'(br_rd_data_valid), 1);
    chk("midrst m0 valid", 64'(m0_rd_data_valid), 0);
    repeat (8) tick;
    chk("midrst beats routed", 64'(vcnt[0] - v0), 0);
    repeat (16) tick;

    rand_lat = 1;
    b0 = n_iss;
    for (int q = 0; q < 2; q++) begin
      ne[q] = 0; nrd[q] = 0; idx[q] = 0; s0[q] = seen[q]; vs[q] = vcnt[q];
    end
    for (int t = 0; t < 1500; t++) begin
      for (int q = 0; q < 2; q++) begin
        if (ne[q] == seen[q] - s0[q] && pn[q] == 0 && cyc >= last_iss + 4 && ne[q] < 256 && $urandom_range(0, 5) == 0) begin
          c = 1'($urandom_range(0, 1));
          a = {1'(q), 20'($urandom)};
          base = {$urandom, $urandom};
          e_a[q][ne[q]] = a; e_c[q][ne[q]] = c; e_b[q][ne[q]] = base;
          ne[q]++;
          if (!c) nrd[q]++;
          send(q, c, a, base);
        end
      end
      tick;
    end
    repeat (40) tick;
    for (int i = b0; i < n_iss; i++) begin
      p = int'(iss_addr[i][20]);
      j = idx[p]++;
      if (j < 256) begin
        chk($sformatf("rnd p%0d #%0d cmd", p, j), 64'(iss_cmd[i]), 64'(e_c[p][j]));
        chk($sformatf("rnd p%0d #%0d addr", p, j), 64'(iss_addr[i]), 64'(e_a[p][j]));
        if (iss_cmd[i])
          for (int k = 0; k < 4; k++) chk($sformatf("rnd p%0d #%0d beat%0d", p, j, k), iss_d[i][k], e_b[p][j] + 64'(k));
      end
    end
    for (int q = 0; q < 2; q++) begin
      chk($sformatf("rnd p%0d issued", q), 64'(idx[q]), 64'(ne[q]));
      chk($sformatf("rnd p%0d read beats", q), 64'(vcnt[q] - vs[q]), 64'(4 * nrd[q]));
    end
    chk("rnd overflow", 64'(overflow), 0);
    chk("read routing", 64'(bad_route), 0);
    chk("command spacing", 64'(bad_gap), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
